// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: drains words from fifo_flops and sends each one over a
// narrow valid/ready link as width/out_width chunks. When one word finishes and
// the FIFO is not empty, the next word starts on the next cycle with no gap.
// Optional feature macro: SER_PARITY_EN adds ser_par, the XOR of the word,
// shown on the last chunk.
module fifo_word_serializer #(
  parameter int width     = 16,
  parameter int out_width = 4,
  parameter bit msb_first = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     fifo_dout,
  input  logic                 fifo_pndng,
  output logic                 fifo_pop,
  output logic [out_width-1:0] ser_data,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_last,
`ifdef SER_PARITY_EN
  output logic                 ser_par,
`endif
  output logic                 busy,
  output logic [15:0]          words_done
);

  localparam int N  = width / out_width;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [width-1:0]     word_q, word_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [15:0]          done_q, done_d;
  logic [out_width-1:0] data_q;
  logic                 last_q;
  logic                 pop_c;
  logic                 fire;
`ifdef SER_PARITY_EN
  logic                 par_q;
`endif

  // Select chunk i of a word. The chunk order depends on msb_first.
  function automatic logic [out_width-1:0] chunk_of(input logic [width-1:0] w,
                                                    input logic [IW-1:0]    i);
    int lo;
    if (msb_first) lo = width - out_width * (int'(i) + 1);
    else           lo = out_width * int'(i);
    return w[lo +: out_width];
  endfunction

  assign fire = (state_q == SEND) && ser_ready;

  // Next-state logic. A new word is loaded either from IDLE or when the last
  // chunk of the current word is accepted, so the held word is never overwritten early.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    done_d  = done_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        pop_c = fifo_pndng;
        if (fifo_pndng) begin
          word_d  = fifo_dout;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            done_d = done_q + 16'd1;
            if (fifo_pndng) begin
              pop_c  = 1'b1;
              word_d = fifo_dout;
              idx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The state registers, plus registered copies of the chunk, last and parity
  // outputs taken from the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      done_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      data_q  <= (state_d == SEND) ? chunk_of(word_d, idx_d) : '0;
      last_q  <= (state_d == SEND) && (idx_d == LAST_IDX);
`ifdef SER_PARITY_EN
      par_q   <= (state_d == SEND) && (idx_d == LAST_IDX) && (^word_d);
`endif
    end
  end

  // Reset has priority, so no word can be popped while the stage is being cleared.
  assign fifo_pop   = pop_c & ~rst;
  assign ser_valid  = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign ser_data   = data_q;
  assign ser_last   = last_q;
  assign words_done = done_q;
`ifdef SER_PARITY_EN
  assign ser_par    = par_q;
`endif

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Testbench for fifo_word_serializer. A queue stands in for the FIFO. Each
// popped word is split into the chunks it should produce, and a monitor on the
// falling edge compares those chunks with every beat the DUT shows.
module tb_fifo_word_serializer;
  localparam int W  = 16;
  localparam int OW = 4;
  localparam int N  = W / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  fifo_dout;
  logic          fifo_pndng;
  logic          fifo_pop;
  logic [OW-1:0] ser_data;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_last;
  logic          busy;
  logic [15:0]   words_done;
`ifdef SER_PARITY_EN
  logic          ser_par;
`endif

  fifo_word_serializer #(.width(W), .out_width(OW), .msb_first(1'b1)) dut (
    .clk(clk), .rst(rst),
    .fifo_dout(fifo_dout), .fifo_pndng(fifo_pndng), .fifo_pop(fifo_pop),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_last(ser_last),
`ifdef SER_PARITY_EN
    .ser_par(ser_par),
`endif
    .busy(busy), .words_done(words_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    bit            last;
    bit            par;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] tbq[$];
  int           n_checks = 0;
  int           n_err    = 0;
  logic [15:0]  model_done = 16'd0;
  bit           mon_en = 1'b0;
  bit           pop_s  = 1'b0;
  bit           rst_s  = 1'b0;
  exp_t         e;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Chunks of a word in MSB-first order: chunk i is bits [W-OW*i-1 : W-OW*(i+1)].
  task automatic push_word(logic [W-1:0] w);
    exp_t x;
    for (int i = 0; i < N; i++) begin
      x.d    = OW'(w >> (W - OW * (i + 1)));
      x.last = (i == N - 1);
      x.par  = x.last && ($countones(w) % 2 == 1);
      expq.push_back(x);
    end
  endtask

  task automatic refresh();
    fifo_pndng = (tbq.size() != 0);
    fifo_dout  = fifo_pndng ? tbq[0] : '0;
  endtask

  // Advance one clock. This also models the FIFO: a pop seen in the previous
  // cycle removes the head word and queues the chunks expected from it.
  task automatic cyc();
    logic [W-1:0] w;
    @(posedge clk); #1;
    if (rst_s) expq.delete();
    if (pop_s && tbq.size() != 0) begin
      w = tbq.pop_front();
      push_word(w);
    end
    refresh();
  endtask

  task automatic drain(int bound);
    int k;
    ser_ready = 1'b1;
    k = 0;
    while ((expq.size() != 0 || tbq.size() != 0 || pop_s) && k < bound) begin
      cyc();
      k++;
    end
    if (k >= bound) chk("drain_timeout", expq.size() + tbq.size(), 0);
    cyc();
  endtask

  // Monitor: check the FIFO handshake rules, the valid state and each beat against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      pop_s = fifo_pop;
      rst_s = rst;
      if (rst)         chk("pop_in_reset", fifo_pop, 0);
      if (!fifo_pndng) chk("pop_when_empty", fifo_pop, 0);
      chk("valid", ser_valid, expq.size() != 0);
      chk("busy", busy, expq.size() != 0);
      chk("words_done", words_done, model_done);
      if (ser_valid && expq.size() != 0) begin
        e = expq[0];
        chk("data", ser_data, e.d);
        chk("last", ser_last, e.last);
`ifdef SER_PARITY_EN
        chk("par", ser_par, e.par);
`endif
        if (fifo_pop) chk("pop_while_held", ser_ready && e.last, 1);
        if (ser_ready && !rst) begin
          void'(expq.pop_front());
          if (e.last) model_done = model_done + 16'd1;
        end
      end
`ifdef SER_PARITY_EN
      else if (!ser_valid) chk("par_idle", ser_par, 0);
`endif
      if (rst) model_done = 16'd0;
    end
  end

  initial begin
    rst = 1'b1; ser_ready = 1'b0;
    tbq.push_back(16'hA5C3);
    refresh();
    // Test 1: three cycles in reset with a word waiting.
    cyc(); mon_en = 1'b1;
    cyc(); cyc();
    chk("rst_valid", ser_valid, 0);
    chk("rst_data", ser_data, 0);
    chk("rst_last", ser_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", words_done, 0);
    // Test 2: the waiting word 0xA5C3 streams out with ready held high.
    rst = 1'b0; ser_ready = 1'b1; refresh();
    drain(50);
    chk("t2_done", words_done, 1);
    // Test 3: ready drops while chunk 5 is shown, and the beat must be held.
    tbq.push_back(16'hA5C3); refresh();
    cyc(); cyc();
    ser_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("t3_hold_data", ser_data, 4'h5);
      chk("t3_hold_valid", ser_valid, 1);
    end
    drain(50);
    chk("t3_done", words_done, 2);
    // Test 4: two words back to back, with no idle cycle between them.
    tbq.push_back(16'h1234); tbq.push_back(16'hBEEF); refresh();
    drain(50);
    chk("t4_done", words_done, 4);
`ifdef SER_PARITY_EN
    tbq.push_back(16'h0001); refresh();
    drain(50);
`endif
    // Test 5: reset while chunk 2 of 0x1234 is shown, then 0x5678 must start from chunk 0.
    tbq.push_back(16'h1234); tbq.push_back(16'h5678); refresh();
    cyc(); cyc(); cyc();
    chk("t5_pre_data", ser_data, 4'h3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_valid", ser_valid, 0);
    chk("t5_done", words_done, 0);
    drain(50);
    chk("t5_after", words_done, 1);
    // Random traffic: ready, pushes and occasional resets are all random.
    for (int c = 0; c < 600; c++) begin
      ser_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      if (tbq.size() < 3 && $urandom_range(0, 2) == 0) tbq.push_back(16'($urandom));
      refresh();
      cyc();
    end
    rst = 1'b0;
    drain(500);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
